// File: rtl/seg_display_capture_pkg.sv
// Shared definitions for the 7-segment readback path.
// Contents: active-high a..g patterns for digits 0-9 (same table the display
// decoders drive), the blank/invalid BCD code and the capture FSM state type.
package seg_pkg;

  // Active-high segment patterns, bit 6 = a .. bit 0 = g
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } cap_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the display decoder: active-high a..g pattern to BCD.
// Ports:
//   pattern  in   7  active-high segments, [6]=a .. [0]=g
//   bcd      out  4  decoded digit, BCD_INVALID when not a digit 0-9
//   valid    out  1  pattern matched one of the ten digit shapes
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    bcd   = BCD_INVALID;
    valid = 1'b1;
    case (pattern)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_display_capture.sv
// Samples a time-multiplexed, active-low 7-segment display bus, decodes each
// settled digit back to BCD and publishes a full frame once every slot was seen.
// Optional feature macro: SEG_ERR_CNT_EN adds the saturating err_count output.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   seg_n         segments active-low, [7]=a .. [1]=g, [0]=dp
//   an_n          digit enables active-low, bit i = slot i
//   frame_digits  captured BCD per slot, slot i at [4i+3:4i]
//   frame_dp      captured decimal points (active-high)
//   frame_valid   1-cycle pulse when frame_digits/frame_dp update
//   pattern_err   1-cycle pulse when a captured pattern is not a digit
//   an_err        1-cycle pulse when a sample has more than one enable low
//   err_count     (SEG_ERR_CNT_EN only) saturating error event counter
module seg_display_capture
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_dp,
  output logic                    frame_valid,
  output logic                    pattern_err,
  output logic                    an_err
`ifdef SEG_ERR_CNT_EN
  ,
  output logic [15:0]             err_count
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [7:0]              s_seg, p_seg;
  logic [NUM_DIGITS-1:0]   s_an, p_an;
  cap_state_t              state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next, cnt_inc;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   seen, seen_next;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    multi, changed, frame_full;
  logic                    capture_c, an_err_c, pattern_err_c;
  logic [3:0]              dec_bcd;
  logic                    dec_valid;

  // Input sample register plus a one-deep history for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg <= '1;
      s_an  <= '1;
      p_seg <= '1;
      p_an  <= '1;
    end else begin
      s_seg <= seg_n;
      s_an  <= an_n;
      p_seg <= s_seg;
      p_an  <= s_an;
    end
  end

  seg_pattern_decode u_decode (
    .pattern (~s_seg[7:1]),
    .bcd     (dec_bcd),
    .valid   (dec_valid)
  );

  // Enable decoding: clearing the lowest set bit leaves a residue only if >1 bit set
  assign sel     = ~s_an;
  assign multi   = |(sel & (sel - NUM_DIGITS'(1)));
  assign changed = {s_an, s_seg} != {p_an, p_seg};
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // Capture FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture FSM next-state and strobes
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture_c  = 1'b0;
    an_err_c   = 1'b0;
    if (sel == '0) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (multi) begin
      an_err_c   = 1'b1;
      state_next = IDLE;
      cnt_next   = '0;
    end else if (changed) begin
      // A new sample is its own first settle count, so STABLE_CYCLES=1 captures here
      cnt_next = CNT_W'(1);
      if (CNT_MAX == CNT_W'(1)) begin
        capture_c  = 1'b1;
        state_next = HELD;
      end else begin
        state_next = SETTLE;
      end
    end else begin
      cnt_next = cnt_inc;
      if (state == SETTLE && cnt_inc == CNT_MAX) begin
        capture_c  = 1'b1;
        state_next = HELD;
      end
    end
  end

  assign pattern_err_c = capture_c & ~dec_valid;
  assign frame_full    = &seen;
  // A capture landing in the publish cycle starts the next frame
  assign seen_next     = (frame_full ? '0 : seen) | (capture_c ? sel : '0);

  // Shadow slot buffer, last capture per slot wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
    end else if (capture_c) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (sel[i]) begin
          shadow_digits[4*i +: 4] <= dec_bcd;
          shadow_dp[i]            <= ~s_seg[0];
        end
      end
    end
  end

  // Frame publish and error strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen         <= '0;
      frame_digits <= '0;
      frame_dp     <= '0;
      frame_valid  <= 1'b0;
      pattern_err  <= 1'b0;
      an_err       <= 1'b0;
    end else begin
      seen        <= seen_next;
      frame_valid <= frame_full;
      pattern_err <= pattern_err_c;
      an_err      <= an_err_c;
      if (frame_full) begin
        frame_digits <= shadow_digits;
        frame_dp     <= shadow_dp;
      end
    end
  end

`ifdef SEG_ERR_CNT_EN
  // Saturating error event counter; one increment per cycle with any error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if ((pattern_err_c || an_err_c) && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_display_capture.sv
// Self-checking bench for seg_display_capture (default NUM_DIGITS=4, STABLE_CYCLES=4).
// Stimulus is a list of hold windows; a window-level model predicts captures,
// frames and error pulses from the display rules.
module tb_seg_display_capture;

  localparam int ND = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_n = 8'hFF;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] frame_digits;
  logic [3:0]  frame_dp;
  logic        frame_valid, pattern_err, an_err;
`ifdef SEG_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  seg_display_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_n        (seg_n),
    .an_n         (an_n),
    .frame_digits (frame_digits),
    .frame_dp     (frame_dp),
    .frame_valid  (frame_valid),
    .pattern_err  (pattern_err),
    .an_err       (an_err)
`ifdef SEG_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation of DUT pulses
  logic [19:0] obs_q[$];
  int          obs_cyc[$];
  int          obs_pe = 0;
  int          obs_ae = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        obs_q.push_back({frame_digits, frame_dp});
        obs_cyc.push_back(cyc);
      end
      if (pattern_err) obs_pe++;
      if (an_err) obs_ae++;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Active-high a..g shapes of digits 0..9
  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  // Window-level reference model
  int          m_dig [4];
  bit          m_dp [4];
  bit   [3:0]  m_seen;
  logic [3:0]  m_prev_an;
  logic [7:0]  m_prev_seg;
  int          m_run;
  bit          m_capt;
  int          m_pe, m_ae;
  logic [19:0] exp_q[$];

  function automatic logic [7:0] enc(input int d, input bit dp);
    logic [6:0] p;
    p = seg_tab[d];
    return ~{p, dp};
  endfunction

  function automatic logic [3:0] slot_an(input int s);
    logic [3:0] a;
    a = 4'hF;
    a[s] = 1'b0;
    return a;
  endfunction

  function automatic int model_decode(input logic [7:0] seg);
    logic [6:0] hi;
    hi = ~seg[7:1];
    for (int d = 0; d < 10; d++) if (hi == seg_tab[d]) return d;
    return 15;
  endfunction

  task automatic model_reset();
    m_seen = '0;
    m_prev_an = 4'hF;
    m_prev_seg = 8'hFF;
    m_run = 0;
    m_capt = 0;
    m_pe = 0;
    m_ae = 0;
    exp_q.delete();
  endtask

  task automatic model_window(input logic [3:0] an, input logic [7:0] seg, input int len);
    int nlow, slot, d;
    logic [19:0] f;
    nlow = $countones(~an);
    if ({an, seg} != {m_prev_an, m_prev_seg}) begin
      m_run = len;
      m_capt = 0;
    end else begin
      m_run += len;
    end
    m_prev_an = an;
    m_prev_seg = seg;
    if (nlow >= 2) m_ae += len;
    if (nlow == 1 && !m_capt && m_run >= SC) begin
      m_capt = 1;
      slot = 0;
      for (int i = 0; i < ND; i++) if (!an[i]) slot = i;
      d = model_decode(seg);
      if (d == 15) m_pe++;
      m_dig[slot] = d;
      m_dp[slot] = !seg[0];
      m_seen[slot] = 1'b1;
      if (m_seen == 4'hF) begin
        for (int i = 0; i < ND; i++) begin
          f[4+4*i +: 4] = 4'(m_dig[i]);
          f[i] = m_dp[i];
        end
        exp_q.push_back(f);
        m_seen = '0;
      end
    end
  endtask

  // Drive one hold window of len sampled cycles; entered and left at posedge+1
  task automatic drive_window(input logic [3:0] an, input logic [7:0] seg, input int len);
    model_window(an, seg, len);
    an_n = an;
    seg_n = seg;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    an_n = 4'hF;
    seg_n = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({frame_digits, frame_dp, frame_valid, pattern_err, an_err} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {frame_digits, frame_dp, frame_valid, pattern_err, an_err});
    end
`ifdef SEG_ERR_CNT_EN
    n_cmp++;
    if (err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_err_count: got %0h expected 0", err_count);
    end
`endif
  endtask

  task automatic test_basic_frame();
    int b, pe0, ae0, t_last;
    do_reset();
    b = obs_q.size(); pe0 = obs_pe; ae0 = obs_ae; t_last = 0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) t_last = cyc;
      drive_window(slot_an(s), enc(s + 1, 0), 8);
    end
    drive_window(4'hF, 8'hFF, 4);
    n_cmp++;
    if (obs_q.size() - b != 1) begin
      n_fail++;
      $display("FAIL basic_frame_count: got %0d expected 1", obs_q.size() - b);
    end else begin
      n_cmp++;
      if (obs_q[b] !== {16'h4321, 4'h0}) begin
        n_fail++;
        $display("FAIL basic_frame_data: got %0h expected %0h", obs_q[b], {16'h4321, 4'h0});
      end
      n_cmp++;
      if (obs_cyc[b] - t_last != SC + 2) begin
        n_fail++;
        $display("FAIL basic_latency: got %0d expected %0d", obs_cyc[b] - t_last, SC + 2);
      end
    end
    n_cmp++;
    if (obs_pe - pe0 != 0 || obs_ae - ae0 != 0) begin
      n_fail++;
      $display("FAIL basic_errors: got pe=%0d ae=%0d expected 0 0", obs_pe - pe0, obs_ae - ae0);
    end
  endtask

  task automatic test_short_slot();
    int b;
    do_reset();
    b = obs_q.size();
    drive_window(slot_an(0), enc(1, 0), 8);
    drive_window(slot_an(1), enc(2, 0), 8);
    drive_window(slot_an(2), enc(3, 0), SC - 1);
    drive_window(slot_an(3), enc(4, 0), 8);
    drive_window(4'hF, 8'hFF, 6);
    n_cmp++;
    if (obs_q.size() != b) begin
      n_fail++;
      $display("FAIL short_no_frame: got %0d frames expected 0", obs_q.size() - b);
    end
    drive_window(slot_an(2), enc(3, 0), SC);
    drive_window(4'hF, 8'hFF, 4);
    n_cmp++;
    if (obs_q.size() - b != 1 || obs_q[obs_q.size() - 1] !== {16'h4321, 4'h0}) begin
      n_fail++;
      $display("FAIL short_then_frame: got %0d frames last %0h expected 1 frame 43210",
               obs_q.size() - b, obs_q.size() > 0 ? obs_q[obs_q.size() - 1] : 20'h0);
    end
  endtask

  task automatic test_an_err();
    int b, pe0, ae0;
    do_reset();
    b = obs_q.size(); pe0 = obs_pe; ae0 = obs_ae;
    drive_window(4'b1100, enc(5, 0), 5);
    drive_window(4'hF, 8'hFF, 4);
    n_cmp++;
    if (obs_ae - ae0 != 5) begin
      n_fail++;
      $display("FAIL an_err_pulses: got %0d expected 5", obs_ae - ae0);
    end
    n_cmp++;
    if (obs_pe != pe0 || obs_q.size() != b) begin
      n_fail++;
      $display("FAIL an_err_side_effects: got pe=%0d frames=%0d expected 0 0",
               obs_pe - pe0, obs_q.size() - b);
    end
`ifdef SEG_ERR_CNT_EN
    n_cmp++;
    if (err_count !== 16'd5) begin
      n_fail++;
      $display("FAIL an_err_count: got %0d expected 5", err_count);
    end
`endif
  endtask

  task automatic test_pattern_err();
    int b, pe0;
    do_reset();
    b = obs_q.size(); pe0 = obs_pe;
    drive_window(slot_an(0), enc(0, 0), 8);
    drive_window(slot_an(1), ~8'b1000_0000, 6);
    drive_window(slot_an(2), enc(2, 0), 8);
    drive_window(slot_an(3), enc(3, 0), 8);
    drive_window(4'hF, 8'hFF, 4);
    n_cmp++;
    if (obs_pe - pe0 != 1) begin
      n_fail++;
      $display("FAIL pattern_err_pulses: got %0d expected 1", obs_pe - pe0);
    end
    n_cmp++;
    if (obs_q.size() - b != 1 || obs_q[obs_q.size() - 1] !== {16'h32F0, 4'h0}) begin
      n_fail++;
      $display("FAIL pattern_err_frame: got %0d frames last %0h expected 1 frame 32f00",
               obs_q.size() - b, obs_q.size() > 0 ? obs_q[obs_q.size() - 1] : 20'h0);
    end
`ifdef SEG_ERR_CNT_EN
    n_cmp++;
    if (err_count !== 16'd1) begin
      n_fail++;
      $display("FAIL pattern_err_count: got %0d expected 1", err_count);
    end
`endif
  endtask

  task automatic test_dp_and_reset();
    int b;
    do_reset();
    b = obs_q.size();
    drive_window(slot_an(0), enc(7, 1), 8);
    drive_window(slot_an(1), enc(1, 0), 8);
    drive_window(slot_an(2), enc(2, 0), 8);
    drive_window(slot_an(3), enc(3, 0), 8);
    drive_window(4'hF, 8'hFF, 4);
    n_cmp++;
    if (obs_q.size() - b != 1 || obs_q[obs_q.size() - 1] !== {16'h3217, 4'h1}) begin
      n_fail++;
      $display("FAIL dp_frame: got %0d frames last %0h expected 1 frame 32171",
               obs_q.size() - b, obs_q.size() > 0 ? obs_q[obs_q.size() - 1] : 20'h0);
    end
    drive_window(slot_an(0), enc(4, 0), 8);
    drive_window(slot_an(1), enc(5, 0), 8);
    drive_window(slot_an(2), enc(6, 0), 8);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({frame_digits, frame_dp, frame_valid, pattern_err, an_err} !== 23'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %0h expected 0",
               {frame_digits, frame_dp, frame_valid, pattern_err, an_err});
    end
    an_n = 4'hF;
    seg_n = 8'hFF;
    @(posedge clk);
    #1 rst_n = 1'b1;
    b = obs_q.size();
    drive_window(slot_an(3), enc(8, 0), 8);
    drive_window(4'hF, 8'hFF, 6);
    n_cmp++;
    if (obs_q.size() != b) begin
      n_fail++;
      $display("FAIL midreset_partial: got %0d frames expected 0", obs_q.size() - b);
    end
    drive_window(slot_an(0), enc(1, 0), 8);
    drive_window(slot_an(1), enc(2, 0), 8);
    drive_window(slot_an(2), enc(3, 0), 8);
    drive_window(4'hF, 8'hFF, 4);
    n_cmp++;
    if (obs_q.size() - b != 1 || obs_q[obs_q.size() - 1] !== {16'h8321, 4'h0}) begin
      n_fail++;
      $display("FAIL midreset_new_frame: got %0d frames last %0h expected 1 frame 83210",
               obs_q.size() - b, obs_q.size() > 0 ? obs_q[obs_q.size() - 1] : 20'h0);
    end
  endtask

  task automatic test_recapture();
    int b;
    do_reset();
    b = obs_q.size();
    drive_window(slot_an(3), enc(5, 0), 8);
    drive_window(slot_an(0), enc(1, 0), 8);
    drive_window(slot_an(3), enc(9, 0), 8);
    drive_window(slot_an(1), enc(2, 0), 8);
    drive_window(slot_an(2), enc(3, 0), 8);
    drive_window(4'hF, 8'hFF, 4);
    n_cmp++;
    if (obs_q.size() - b != 1 || obs_q[obs_q.size() - 1] !== {16'h9321, 4'h0}) begin
      n_fail++;
      $display("FAIL recapture_frame: got %0d frames last %0h expected 1 frame 93210",
               obs_q.size() - b, obs_q.size() > 0 ? obs_q[obs_q.size() - 1] : 20'h0);
    end
  endtask

  task automatic test_random();
    int b, pe0, ae0, r, len, nf;
    logic [3:0] an;
    logic [7:0] seg;
    do_reset();
    b = obs_q.size(); pe0 = obs_pe; ae0 = obs_ae;
    for (int w = 0; w < 80; w++) begin
      r = $urandom_range(0, 9);
      if (r < 7) begin
        an = slot_an($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) seg = 8'($urandom);
        else seg = enc($urandom_range(0, 9), 1'($urandom_range(0, 1)));
      end else if (r < 8) begin
        an = 4'hF;
        seg = 8'($urandom);
      end else begin
        do an = 4'($urandom); while ($countones(~an) < 2);
        seg = 8'($urandom);
      end
      len = $urandom_range(1, 8);
      drive_window(an, seg, len);
    end
    drive_window(4'hF, 8'hFF, 8);
    nf = obs_q.size() - b;
    n_cmp++;
    if (nf != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_frame_count: got %0d expected %0d", nf, exp_q.size());
    end
    for (int i = 0; i < nf && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[b + i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_frame_%0d: got %0h expected %0h", i, obs_q[b + i], exp_q[i]);
      end
    end
    n_cmp++;
    if (obs_pe - pe0 != m_pe) begin
      n_fail++;
      $display("FAIL random_pattern_err: got %0d expected %0d", obs_pe - pe0, m_pe);
    end
    n_cmp++;
    if (obs_ae - ae0 != m_ae) begin
      n_fail++;
      $display("FAIL random_an_err: got %0d expected %0d", obs_ae - ae0, m_ae);
    end
`ifdef SEG_ERR_CNT_EN
    n_cmp++;
    if (err_count !== 16'(m_pe + m_ae)) begin
      n_fail++;
      $display("FAIL random_err_count: got %0d expected %0d", err_count, m_pe + m_ae);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_short_slot();
    test_an_err();
    test_pattern_err();
    test_dp_and_reset();
    test_recapture();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
